// File: rtl/pitch_pkg.sv
// Shared types and default widths for the pitch-detection frame pipeline.
package pitch_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CAPTURE,
    ST_REPORT,
    ST_HOLD
  } state_t;

  // |re|+|im| of a default-width bin; one extra bit so the sum never overflows.
  typedef logic [DATA_WIDTH_DEF:0] mag_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// FFT bin stream plus the peak-report/phase handshake between the sequencer and its neighbours.
interface frame_sequencer_if
  import pitch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [2*DATA_WIDTH-1:0] fft_tdata;
  logic                    fft_tvalid;
  logic                    fft_tlast;
  logic [15:0]             fft_tuser;
  logic                    fft_tready;
  logic [ADDR_WIDTH-1:0]   k_max;
  logic                    k_max_valid;
  logic                    phases_valid;
  logic                    frame_start;
  logic                    error;

  modport master (
    output fft_tdata, fft_tvalid, fft_tlast, fft_tuser, phases_valid,
    input  fft_tready, k_max, k_max_valid, frame_start, error
  );

  modport slave (
    input  fft_tdata, fft_tvalid, fft_tlast, fft_tuser, phases_valid,
    output fft_tready, k_max, k_max_valid, frame_start, error
  );

endinterface

// File: rtl/peak_search.sv
// Running-maximum tracker over |re|+|im| of the bins it is enabled for.
module peak_search
  import pitch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_enable,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0]   i_index,
  output logic [ADDR_WIDTH-1:0]   o_nextIdx
);

  logic [DATA_WIDTH-1:0] w_reBits;
  logic [DATA_WIDTH-1:0] w_imBits;
  logic [DATA_WIDTH-1:0] w_absRe;
  logic [DATA_WIDTH-1:0] w_absIm;
  logic [DATA_WIDTH:0]   w_mag;
  logic [DATA_WIDTH:0]   w_nextMag;
  logic [ADDR_WIDTH-1:0] w_nextIdx;
  logic [DATA_WIDTH:0]   r_peakMag;
  logic [ADDR_WIDTH-1:0] r_peakIdx;

  assign w_reBits = i_data[DATA_WIDTH-1:0];
  assign w_imBits = i_data[2*DATA_WIDTH-1:DATA_WIDTH];

  // Unsigned negate: the most-negative value maps to 2^(DATA_WIDTH-1) exactly.
  assign w_absRe = w_reBits[DATA_WIDTH-1] ? (~w_reBits + 1'b1) : w_reBits;
  assign w_absIm = w_imBits[DATA_WIDTH-1] ? (~w_imBits + 1'b1) : w_imBits;
  assign w_mag   = {1'b0, w_absRe} + {1'b0, w_absIm};

  always_comb begin
    w_nextMag = r_peakMag;
    w_nextIdx = r_peakIdx;
    if (i_enable && (w_mag > r_peakMag)) begin
      w_nextMag = w_mag;
      w_nextIdx = i_index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_peakMag <= '0;
      r_peakIdx <= '0;
    end else if (i_clear) begin
      r_peakMag <= '0;
      r_peakIdx <= '0;
    end else begin
      r_peakMag <= w_nextMag;
      r_peakIdx <= w_nextIdx;
    end
  end

  assign o_nextIdx = w_nextIdx;

endmodule

// File: rtl/frame_sequencer.sv
// Requests FFT frames on a fixed hop, finds the peak bin of each frame and
// holds it for the phase detector until it reports done or times out.
module frame_sequencer
  import pitch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int HOP_CYCLES = 15000,
  parameter int TIMEOUT    = 4096
) (
  input logic              clock,
  input logic              reset,
  frame_sequencer_if.slave bus
);

  localparam int HW = $clog2(HOP_CYCLES + 1) + 1;
  localparam int TW = $clog2(TIMEOUT + 1) + 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [HW-1:0] HOP_LAST = HW'(HOP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] BINS_N   = CW'(2 ** ADDR_WIDTH);
  localparam logic [15:0]   HALF_N   = 16'(2 ** (ADDR_WIDTH - 1));

  state_t                r_state;
  state_t                w_next;
  logic [HW-1:0]         r_hop;
  logic [TW-1:0]         r_timeout;
  logic [CW-1:0]         r_binCount;
  logic [CW-1:0]         w_binsInc;
  logic [ADDR_WIDTH-1:0] r_kMax;
  logic                  r_error;
  logic                  w_accept;
  logic                  w_lastAccept;
  logic                  w_inRange;
  logic                  w_hopDone;
  logic                  w_timedOut;
  logic                  w_clearPeak;
  logic [ADDR_WIDTH-1:0] w_nextIdx;

  assign w_accept     = (r_state == ST_CAPTURE) && bus.fft_tvalid;
  assign w_lastAccept = w_accept && bus.fft_tlast;
  assign w_inRange    = (bus.fft_tuser != 16'd0) && (bus.fft_tuser < HALF_N);
  assign w_binsInc    = (r_binCount == '1) ? r_binCount : r_binCount + 1'b1;
  assign w_hopDone    = (r_hop >= HOP_LAST);
  assign w_timedOut   = (r_timeout >= TO_LAST);
  assign w_clearPeak  = (r_state == ST_START);

  peak_search #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_peakSearch (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clearPeak),
    .i_enable (w_accept && w_inRange),
    .i_data   (bus.fft_tdata),
    .i_index  (bus.fft_tuser[ADDR_WIDTH-1:0]),
    .o_nextIdx(w_nextIdx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = ST_START;
      ST_START:   w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_lastAccept) w_next = ST_REPORT;
      ST_REPORT:  if (bus.phases_valid || w_timedOut) w_next = ST_HOLD;
      ST_HOLD:    if (w_hopDone) w_next = ST_START;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.fft_tready  = (r_state == ST_CAPTURE);
    bus.frame_start = (r_state == ST_START);
    bus.k_max_valid = (r_state == ST_REPORT);
  end

  // r_hop counts cycles elapsed since the START cycle, so the START cycle itself
  // is 0 and the next START lands exactly HOP_CYCLES later when already due.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hop      <= '0;
      r_timeout  <= '0;
      r_binCount <= '0;
      r_kMax     <= '0;
      r_error    <= 1'b0;
    end else begin
      if (r_state == ST_START) r_hop <= HW'(1);
      else if (!w_hopDone)     r_hop <= r_hop + 1'b1;

      if (r_state != ST_REPORT) r_timeout <= '0;
      else if (!w_timedOut)     r_timeout <= r_timeout + 1'b1;

      if (r_state == ST_START) r_binCount <= '0;
      else if (w_accept)       r_binCount <= w_binsInc;

      if (w_lastAccept) begin
        r_kMax <= w_nextIdx;
        if (w_binsInc != BINS_N) r_error <= 1'b1;
      end

      if ((r_state == ST_REPORT) && !bus.phases_valid && w_timedOut) r_error <= 1'b1;
    end
  end

  assign bus.k_max = r_kMax;
  assign bus.error = r_error;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed frame sequence with randomized bin data, checked against a peak model.
module tb_frame_sequencer;

  localparam int AW   = 11;
  localparam int DW   = 24;
  localparam int NB   = 2 ** AW;
  localparam int HOP  = 15000;
  localparam int TOUT = 4096;

  logic clock;
  logic reset;

  frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  frame_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .HOP_CYCLES(HOP),
    .TIMEOUT   (TOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;
  int fsCycles[$];

  logic [DW-1:0] reArr [NB];
  logic [DW-1:0] imArr [NB];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  // Every frame_start pulse is logged by the cycle it was seen in.
  always @(negedge clock) begin
    if (bus.frame_start === 1'b1) fsCycles.push_back(cycleCount);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic longint absVal(input logic [DW-1:0] v);
    longint x;
    x = longint'($signed(v));
    return (x < 0) ? -x : x;
  endfunction

  // Peak bin: largest |re|+|im| among indices 1..N/2-1, earliest index on ties.
  function automatic int refPeak(input int len);
    longint best;
    longint m;
    int     bestIdx;
    best    = 0;
    bestIdx = 0;
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i < NB / 2) begin
        m = absVal(reArr[i]) + absVal(imArr[i]);
        if (m > best) begin
          best    = m;
          bestIdx = i;
        end
      end
    end
    return bestIdx;
  endfunction

  task automatic fillRandom(input int span);
    for (int i = 0; i < NB; i++) begin
      if (span == 0) begin
        reArr[i] = DW'($urandom);
        imArr[i] = DW'($urandom);
      end else begin
        reArr[i] = DW'(int'($urandom_range(0, 2 * span)) - span);
        imArr[i] = DW'(int'($urandom_range(0, 2 * span)) - span);
      end
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (bus.fft_tready !== 1'b1 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, bus.fft_tready, 1);
  endtask

  // Streams bins 0..len-1 with random idle gaps; resetAt >= 0 asserts reset
  // before that bin is presented and abandons the frame.
  task automatic applyStimulus(input int len, input int resetAt);
    int i;
    i = 0;
    while (i < len) begin
      if (i == resetAt) begin
        reset          = 1'b1;
        bus.fft_tvalid = 1'b0;
        bus.fft_tlast  = 1'b0;
        return;
      end
      if ($urandom_range(0, 7) == 0) begin
        bus.fft_tvalid = 1'b0;
      end else begin
        bus.fft_tdata  = {imArr[i], reArr[i]};
        bus.fft_tuser  = 16'(i);
        bus.fft_tlast  = (i == len - 1);
        bus.fft_tvalid = 1'b1;
        i++;
      end
      @(negedge clock);
    end
    bus.fft_tvalid = 1'b0;
    bus.fft_tlast  = 1'b0;
  endtask

  task automatic releaseAndCheck(input string pfx);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput({pfx, "_fs_idle"}, bus.frame_start, 0);
    @(negedge clock);
    checkOutput({pfx, "_fs_pulse"}, bus.frame_start, 1);
    checkOutput({pfx, "_kmax"}, bus.k_max, 0);
    checkOutput({pfx, "_error"}, bus.error, 0);
    @(negedge clock);
    checkOutput({pfx, "_fs_single"}, bus.frame_start, 0);
    checkOutput({pfx, "_tready"}, bus.fft_tready, 1);
  endtask

  task automatic pulsePhases();
    bus.phases_valid = 1'b1;
    tick(1);
    bus.phases_valid = 1'b0;
  endtask

  task automatic checkHop(input string tag, input int idx);
    checkOutput({tag, "_fs_count"}, fsCycles.size(), idx + 1);
    if (fsCycles.size() > idx)
      checkOutput({tag, "_hop"}, fsCycles[idx] - fsCycles[idx-1], HOP);
  endtask

  initial begin
    int expIdx;
    int n;

    reset            = 1'b1;
    bus.fft_tdata    = '0;
    bus.fft_tvalid   = 1'b0;
    bus.fft_tlast    = 1'b0;
    bus.fft_tuser    = '0;
    bus.phases_valid = 1'b0;
    tick(4);
    checkOutput("rst_tready", bus.fft_tready, 0);
    checkOutput("rst_kvalid", bus.k_max_valid, 0);
    checkOutput("rst_fs", bus.frame_start, 0);
    checkOutput("rst_kmax", bus.k_max, 0);
    checkOutput("rst_error", bus.error, 0);
    releaseAndCheck("boot");

    // Frame 1: single strong bin among {1,1}.
    for (int i = 0; i < NB; i++) begin
      reArr[i] = DW'(1);
      imArr[i] = DW'(1);
    end
    reArr[25] = DW'(400);
    imArr[25] = DW'(-300);
    applyStimulus(NB, -1);
    checkOutput("f1_kvalid", bus.k_max_valid, 1);
    checkOutput("f1_kmax", bus.k_max, 25);
    checkOutput("f1_kmax_model", bus.k_max, refPeak(NB));
    checkOutput("f1_tready_off", bus.fft_tready, 0);
    checkOutput("f1_error", bus.error, 0);
    tick(49);
    pulsePhases();
    checkOutput("f1_kvalid_drop", bus.k_max_valid, 0);
    checkOutput("f1_kmax_hold", bus.k_max, 25);
    waitReady("f2_wait");
    checkHop("f2", 1);

    // Frame 2: ties at 10/40, larger values at DC and above N/2, random fill below.
    fillRandom(400);
    reArr[10]   = DW'(600);   imArr[10]   = DW'(-400);
    reArr[40]   = DW'(-1000); imArr[40]   = DW'(0);
    reArr[0]    = DW'(5000);  imArr[0]    = DW'(0);
    reArr[1500] = DW'(-2500); imArr[1500] = DW'(-2500);
    applyStimulus(NB, -1);
    checkOutput("f2_kmax", bus.k_max, 10);
    checkOutput("f2_kmax_model", bus.k_max, refPeak(NB));
    tick($urandom_range(1, 100));
    checkOutput("f2_kvalid_wait", bus.k_max_valid, 1);
    pulsePhases();
    checkOutput("f2_kvalid_drop", bus.k_max_valid, 0);
    waitReady("f3_wait");
    checkHop("f3", 2);

    // Frame 3: full-range random data, phase detector never answers.
    fillRandom(0);
    reArr[0]    = DW'(24'h7FFFFF); imArr[0]    = DW'(24'h7FFFFF);
    reArr[1500] = DW'(24'h800000); imArr[1500] = DW'(24'h800000);
    applyStimulus(NB, -1);
    expIdx = refPeak(NB);
    checkOutput("f3_kmax_model", bus.k_max, expIdx);
    checkOutput("f3_error_before", bus.error, 0);
    n = 0;
    while (bus.k_max_valid === 1'b1 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    checkOutput("f3_timeout_len", n, TOUT);
    checkOutput("f3_error_after", bus.error, 1);
    checkOutput("f3_kmax_kept", bus.k_max, expIdx);
    waitReady("f4_wait");
    checkHop("f4", 3);

    // Frame 4: reset lands mid-capture.
    fillRandom(0);
    applyStimulus(NB, 500);
    #1;
    checkOutput("mid_rst_tready", bus.fft_tready, 0);
    checkOutput("mid_rst_kvalid", bus.k_max_valid, 0);
    checkOutput("mid_rst_fs", bus.frame_start, 0);
    checkOutput("mid_rst_kmax", bus.k_max, 0);
    checkOutput("mid_rst_error", bus.error, 0);
    tick(3);
    releaseAndCheck("mid");
    checkOutput("mid_fs_count", fsCycles.size(), 5);

    // Frame 5: tlast at bin 1000, magnitude extremes near the front.
    fillRandom(0);
    reArr[5] = DW'(24'h7FFFFF); imArr[5] = DW'(24'h7FFFFF);
    reArr[7] = DW'(24'h800000); imArr[7] = DW'(24'h800000);
    applyStimulus(1001, -1);
    checkOutput("f5_kvalid", bus.k_max_valid, 1);
    checkOutput("f5_error", bus.error, 1);
    checkOutput("f5_kmax", bus.k_max, 7);
    checkOutput("f5_kmax_model", bus.k_max, refPeak(1001));
    pulsePhases();
    checkOutput("f5_kvalid_drop", bus.k_max_valid, 0);
    tick(20);
    checkOutput("end_fs_count", fsCycles.size(), 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning log2 FFT length N.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, meaning signed width of each of re/im.
REQ-003 SHALL have parameter HOP_CYCLES, default 15000, meaning minimum cycles from one frame_start to the next.
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles to wait for phases_valid.
REQ-005 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port fft_tdata  in  2*DATA_WIDTH  {im,re}, signed two's complement.
REQ-008 SHALL have ports fft_tvalid/fft_tlast  in  1 each  AXI-stream valid / last bin of frame.
REQ-009 SHALL have port fft_tuser  in  16  bin index in [ADDR_WIDTH-1:0].
REQ-010 SHALL have port fft_tready  out  1  sequencer accepts a bin.
REQ-011 SHALL have port k_max  out  ADDR_WIDTH  peak bin of last completed frame.
REQ-012 SHALL have port k_max_valid  out  1  level; k_max stable while high.
REQ-013 SHALL have port phases_valid  in  1  phase detector finished frame.
REQ-014 SHALL have ports frame_start  out  1  one-cycle pulse requesting next FFT frame; error  out  1  sticky fault flag.

Function
REQ-015 SHALL implement FSM states IDLE, START, CAPTURE, REPORT, HOLD.
REQ-016 SHALL go IDLE->START on the first cycle after reset release; START pulses frame_start for exactly one cycle, clears hop counter, then goes to CAPTURE.
REQ-017 SHALL in CAPTURE drive fft_tready=1; a bin is accepted only on fft_tvalid&fft_tready.
REQ-018 SHALL compute magnitude as |re|+|im| in DATA_WIDTH+1 unsigned bits; |most-negative| = 2^(DATA_WIDTH-1), no saturation.
REQ-019 SHALL consider only indices 1..N/2-1; DC and indices >= N/2 ignored for peak search.
REQ-020 SHALL replace the running peak only on strictly greater magnitude (ties keep the lowest index); running peak cleared to 0 / index 0 at START.
REQ-021 SHALL on accepted fft_tlast go to REPORT; if accepted-bin count != N at tlast, set error and still go to REPORT.
REQ-022 SHALL in REPORT register k_max, assert k_max_valid, deassert fft_tready, start timeout counter.
REQ-023 SHALL leave REPORT for HOLD on phases_valid=1, or on TIMEOUT cycles elapsed (sets error); k_max_valid drops on that transition.
REQ-024 SHALL in HOLD wait until hop counter (running since START pulse) >= HOP_CYCLES-1, then go to START; if already satisfied, HOLD lasts one cycle.
REQ-025 SHALL ignore phases_valid outside REPORT, and fft_tvalid outside CAPTURE (tready=0, no loss claimed).
REQ-026 SHALL saturate hop and timeout counters at their terminal value (no wrap).
REQ-027 SHALL keep k_max at its previous value outside REPORT-entry; frame_start never asserted outside START.

Reset
REQ-028 SHALL, on reset, asynchronously force state IDLE, fft_tready=0, k_max=0, k_max_valid=0, frame_start=0, error=0, all counters and peak registers 0.
REQ-029 SHALL abandon any in-flight frame on reset mid-CAPTURE/REPORT; no frame_start until one cycle after release.

Structure
REQ-030 SHALL take state enum, magnitude type and ADDR_WIDTH/DATA_WIDTH defaults from shared package pitch_pkg.
REQ-031 SHALL place magnitude and compare-update in one sub-module peak_search (running max, index, clear input).

Verification
REQ-032 SHALL check reset: after release, frame_start pulses once 2 cycles later, k_max=0, error=0.
REQ-033 SHALL check peak: N=2048, bin 25 = {im=-300,re=400}, others {1,1} -> k_max=25, k_max_valid high from the cycle after tlast.
REQ-034 SHALL check ties/range: bins 10 and 40 magnitude 1000, bin 0 and bin 1500 magnitude 5000 -> k_max=10.
REQ-035 SHALL check hop: phases_valid 50 cycles after k_max_valid, HOP_CYCLES=15000 -> next frame_start exactly 15000 cycles after previous.
REQ-036 SHALL check faults: tlast at bin 1000 -> error=1; separately no phases_valid -> k_max_valid drops after 4096 cycles, error=1, sequencing continues.
REQ-037 SHALL check reset asserted mid-CAPTURE at bin 500 -> outputs reset immediately, new frame_start after release.
